loop_sequencer: RTL and testbench

- Controller FSM that sequences a down-count loop datapath.
- Loads an iteration count, issues one handshaked step request per iteration, and decrements.
- Terminates when the count register's equal-to-zero flag asserts.
- Sits between the instruction control unit (start/abort) and a functional unit that performs one loop-body operation per step handshake.

---
 rtl/loop_sequencer.sv | 77 +++++++
 tb/tb_loop_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/loop_sequencer.sv
// Down-count loop controller: loads an iteration count, issues one handshaked
// step request per iteration and decrements until the count reaches zero.
module loop_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic             abort,
    input  logic             step_ack,
    output logic             step_req,
    output logic             busy,
    output logic [WIDTH-1:0] cnt,
    output logic             aeq0,
    output logic             done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_DEC   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = n;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort)     state_d = S_IDLE;
                else if (aeq0) state_d = S_DONE;
                else           state_d = S_REQ;
            end
            S_REQ: begin
                // abort beats a same-cycle ack, so the step is dropped uncounted
                if (abort)         state_d = S_IDLE;
                else if (step_ack) state_d = S_DEC;
            end
            S_DEC: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign aeq0     = (cnt_q == '0);
    assign cnt      = cnt_q;
    assign busy     = (state_q != S_IDLE);
    assign step_req = (state_q == S_REQ);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_loop_sequencer.sv
module tb_loop_sequencer;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] n = '0;
  logic             abort = 1'b0;
  logic             step_ack = 1'b0;
  logic             step_req, busy, aeq0, done;
  logic [WIDTH-1:0] cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_step[$];
  int exp_done[$];

  loop_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n), .abort(abort),
    .step_ack(step_ack), .step_req(step_req), .busy(busy),
    .cnt(cnt), .aeq0(aeq0), .done(done)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("aeq0", aeq0, (cnt == '0));
      if (step_req && step_ack && !abort) begin
        chk("step_pending", (exp_step.size() > 0), 1'b1);
        if (exp_step.size() > 0) begin
          int e;
          e = exp_step.pop_front();
          chk("step_cnt", int'(cnt), e);
        end
      end
      if (done) begin
        chk("done_pending", (exp_done.size() > 0), 1'b1);
        if (exp_done.size() > 0) begin
          int e;
          e = exp_done.pop_front();
          chk("done_cycle", cyc, e);
          chk("done_cnt", int'(cnt), 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_loop(input int k, input int dly, input int steps_kept);
    for (int i = 0; i < steps_kept; i++) exp_step.push_back(k - i);
    if (steps_kept == k) exp_done.push_back(cyc + 3 * k + 2 + k * dly);
    start = 1'b1;
    n     = WIDTH'(k);
    tick();
    start = 1'b0;
  endtask

  task automatic serve(input int dly, input bit with_abort);
    int t;
    t = 0;
    while (!step_req && t < 50) begin
      tick();
      t++;
    end
    chk("req_seen", step_req, 1'b1);
    step_ack = 1'b0;
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("req_hold", step_req, 1'b1);
    end
    step_ack = 1'b1;
    abort    = with_abort;
    tick();
    step_ack = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic wait_empty(input int limit);
    int t;
    t = 0;
    while ((exp_done.size() + exp_step.size()) != 0 && t < limit) begin
      tick();
      t++;
    end
    chk("timeout", exp_done.size() + exp_step.size(), 0);
    chk("idle_after", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_req", step_req, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_aeq0", aeq0, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    chk("idle_busy", busy, 1'b0);
    chk("idle_cnt", int'(cnt), 0);

    step_ack = 1'b1;
    start_loop(0, 0, 0);
    chk("z_busy", busy, 1'b1);
    wait_empty(20);

    start_loop(3, 0, 3);
    wait_empty(50);
    chk("n3_cnt", int'(cnt), 0);

    step_ack = 1'b0;
    start_loop(2, 4, 2);
    serve(4, 1'b0);
    serve(4, 1'b0);
    wait_empty(50);
    chk("dly_cnt", int'(cnt), 0);

    start_loop(5, 0, 1);
    serve(0, 1'b0);
    serve(0, 1'b1);
    chk("ab_busy", busy, 1'b0);
    chk("ab_cnt", int'(cnt), 4);
    for (int i = 0; i < 5; i++) tick();
    chk("ab_hold_cnt", int'(cnt), 4);
    start_loop(1, 0, 1);
    serve(0, 1'b0);
    wait_empty(30);

    step_ack = 1'b1;
    start_loop(4, 0, 4);
    tick();
    tick();
    tick();
    start = 1'b1;
    n     = 8'd7;
    tick();
    start = 1'b0;
    wait_empty(60);

    start_loop(5, 0, 5);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    exp_step.delete();
    exp_done.delete();
    chk("mr_busy", busy, 1'b0);
    chk("mr_cnt", int'(cnt), 0);
    chk("mr_done", done, 1'b0);
    rst = 1'b0;
    tick();

    start_loop(255, 0, 255);
    wait_empty(1000);
    chk("max_cnt", int'(cnt), 0);
    step_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
